// File: rtl/ula_pkg.sv
// ULA sweep driver shared widths, FSM states and function opcodes.
// ula_ref is the golden ULA used by the ULA_SELF_CHECK_EN build.
package ula_pkg;

  localparam int NB_OP = 2;
  localparam int NB_F = 3;
  localparam int NB_RES = 2;
  localparam int HIST_DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE
  } state_t;

  localparam logic [NB_F-1:0] F_AND   = 3'b000;
  localparam logic [NB_F-1:0] F_OR    = 3'b001;
  localparam logic [NB_F-1:0] F_ADD   = 3'b010;
  localparam logic [NB_F-1:0] F_UNDEF = 3'b011;
  localparam logic [NB_F-1:0] F_ANDN  = 3'b100;
  localparam logic [NB_F-1:0] F_ORN   = 3'b101;
  localparam logic [NB_F-1:0] F_SUB   = 3'b110;
  localparam logic [NB_F-1:0] F_SLT   = 3'b111;

  function automatic logic [NB_RES-1:0] ula_ref(
    input logic [NB_OP-1:0] a,
    input logic [NB_OP-1:0] b,
    input logic [NB_F-1:0]  f
  );
    logic [NB_OP-1:0] r;
    r = '0;
    case (f)
      F_AND:   r = a & b;
      F_OR:    r = a | b;
      F_ADD:   r = a + b;
      F_ANDN:  r = a & ~b;
      F_ORN:   r = a | ~b;
      F_SUB:   r = a - b;
      F_SLT:   r = NB_OP'(a < b);
      default: r = '0;
    endcase
    return NB_RES'(r);
  endfunction

endpackage

// File: rtl/ula_hist_buf.sv
// Circular result history: newest entry at idx 0.
// Entries at or beyond the saturating count read back as zero.
module ula_hist_buf
  import ula_pkg::*;
#(
  parameter int W     = NB_RES,
  parameter int DEPTH = HIST_DEPTH_DEF,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic [IW-1:0] idx,
  output logic [W-1:0]  dout
);

  logic [W-1:0]  mem [DEPTH];
  logic [IW-1:0] wptr;
  logic [IW:0]   count;
  logic [IW-1:0] rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      count <= '0;
    end else if (push) begin
      wptr <= wptr + IW'(1);
      if (count != (IW+1)'(DEPTH))
        count <= count + (IW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= din;
  end

  assign rd = wptr - IW'(1) - idx;

  always_comb begin
    dout = '0;
    if ({1'b0, idx} < count)
      dout = mem[rd];
  end

endmodule

// File: rtl/ula_sweep_driver.sv
// ULA initiator: single op or 16-combination sweep, checksum and history.
// Define ULA_SELF_CHECK_EN to add the reference-model mismatch ports.
module ula_sweep_driver
  import ula_pkg::*;
#(
  parameter int NBITS_OPERADORES = NB_OP,
  parameter int NBITS_F          = NB_F,
  parameter int NBITS_RESULTADO  = NB_RES,
  parameter int HIST_DEPTH       = HIST_DEPTH_DEF
) (
  input  logic                          clk_2,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          mode,
  input  logic [NBITS_OPERADORES-1:0]   a_in,
  input  logic [NBITS_OPERADORES-1:0]   b_in,
  input  logic [NBITS_F-1:0]            f_in,
  output logic [NBITS_OPERADORES-1:0]   alu_a,
  output logic [NBITS_OPERADORES-1:0]   alu_b,
  output logic [NBITS_F-1:0]            alu_f,
  input  logic [NBITS_RESULTADO-1:0]    alu_y,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [NBITS_RESULTADO-1:0]    result,
  output logic [7:0]                    checksum,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
`ifdef ULA_SELF_CHECK_EN
  output logic                          mismatch,
  output logic [7:0]                    mismatch_cnt,
`endif
  output logic [NBITS_RESULTADO-1:0]    hist_data
);

  localparam int PW = 2 * NBITS_OPERADORES;

  state_t        state, state_next;
  logic          start_q;
  logic          start_rise;
  logic          sweep;
  logic [PW-1:0] pair;
  logic          last;

  assign start_rise = start & ~start_q;
  assign pair       = {alu_a, alu_b};
  assign last       = &pair;
  assign busy       = (state == CAPTURE);
  assign done       = (state == DONE);

  always_ff @(posedge clk_2) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start_rise)
          state_next = (f_in == F_UNDEF) ? DONE : CAPTURE;
      end
      CAPTURE: begin
        if (!sweep || last)
          state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      start_q  <= 1'b0;
      sweep    <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_f    <= '0;
      err      <= 1'b0;
      result   <= '0;
      checksum <= '0;
    end else begin
      start_q <= start;
      unique case (state)
        IDLE: begin
          if (start_rise) begin
            if (f_in == F_UNDEF) begin
              err <= 1'b1;
            end else begin
              alu_f    <= f_in;
              err      <= 1'b0;
              checksum <= '0;
              sweep    <= mode;
              alu_a    <= mode ? '0 : a_in;
              alu_b    <= mode ? '0 : b_in;
            end
          end
        end
        CAPTURE: begin
          result   <= alu_y;
          checksum <= checksum + 8'(alu_y);
          if (sweep && !last)
            {alu_a, alu_b} <= pair + PW'(1);
        end
        default: ;
      endcase
    end
  end

  ula_hist_buf #(
    .W     (NBITS_RESULTADO),
    .DEPTH (HIST_DEPTH)
  ) u_hist (
    .clk  (clk_2),
    .rst  (reset),
    .push (busy),
    .din  (alu_y),
    .idx  (hist_idx),
    .dout (hist_data)
  );

`ifdef ULA_SELF_CHECK_EN
  logic [NBITS_RESULTADO-1:0] y_exp;

  assign y_exp = ula_ref(alu_a, alu_b, alu_f);

  always_ff @(posedge clk_2) begin
    if (reset) begin
      mismatch     <= 1'b0;
      mismatch_cnt <= '0;
    end else if (state == IDLE && start_rise) begin
      mismatch <= 1'b0;
    end else if (busy && alu_y != y_exp) begin
      mismatch <= 1'b1;
      if (mismatch_cnt != 8'hff)
        mismatch_cnt <= mismatch_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ula_sweep_driver.sv
// Directed and randomized runs of ula_sweep_driver against a ULA model,
// with expected checksum, result and history computed per run.
module tb_ula_sweep_driver;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [1:0] a_in = '0;
  logic [1:0] b_in = '0;
  logic [2:0] f_in = '0;
  logic [1:0] alu_a, alu_b;
  logic [2:0] alu_f;
  logic [1:0] alu_y;
  logic       busy, done, err;
  logic [1:0] result;
  logic [7:0] checksum;
  logic [2:0] hist_idx = '0;
  logic [1:0] hist_data;
`ifdef ULA_SELF_CHECK_EN
  logic       mismatch;
  logic [7:0] mismatch_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  int         exp_cks = 0;
  logic [1:0] exp_res = '0;
  logic       exp_err = 1'b0;
  logic [1:0] hist_q[$];

  always #5 clk_2 = ~clk_2;

  function automatic logic [1:0] model_y(input int a, input int b, input int f);
    int r;
    case (f)
      0: r = a & b;
      1: r = a | b;
      2: r = a + b;
      4: r = a & (3 - b);
      5: r = a | (3 - b);
      6: r = a - b + 4;
      7: r = (a < b) ? 1 : 0;
      default: r = 0;
    endcase
    return 2'(r % 4);
  endfunction

  assign alu_y = model_y(int'(alu_a), int'(alu_b), int'(alu_f));

  ula_sweep_driver dut (
    .clk_2    (clk_2),
    .reset    (reset),
    .start    (start),
    .mode     (mode),
    .a_in     (a_in),
    .b_in     (b_in),
    .f_in     (f_in),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_f    (alu_f),
    .alu_y    (alu_y),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .result   (result),
    .checksum (checksum),
    .hist_idx (hist_idx),
`ifdef ULA_SELF_CHECK_EN
    .mismatch     (mismatch),
    .mismatch_cnt (mismatch_cnt),
`endif
    .hist_data (hist_data)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_hist(input string tag);
    for (int i = 0; i < 8; i++) begin
      hist_idx = 3'(i);
      #1;
      check($sformatf("%s_hist%0d", tag, i), 32'(hist_data),
            (i < hist_q.size()) ? 32'(hist_q[i]) : 32'd0);
    end
  endtask

  task automatic run_op(input bit m, input int a, input int b, input int f,
                        input bit retoggle, input string tag);
    int bc, dc, dat, nops;
    int aa, bb;
    logic [1:0] y;
    @(negedge clk_2);
    start = 1'b0;
    @(negedge clk_2);
    mode = m;
    a_in = 2'(a);
    b_in = 2'(b);
    f_in = 3'(f);
    start = 1'b1;
    nops = (f == 3) ? 0 : (m ? 16 : 1);
    if (f == 3) begin
      exp_err = 1'b1;
    end else begin
      exp_err = 1'b0;
      exp_cks = 0;
      for (int i = 0; i < nops; i++) begin
        aa = m ? i / 4 : a;
        bb = m ? i % 4 : b;
        y = model_y(aa, bb, f);
        exp_res = y;
        exp_cks = (exp_cks + int'(y)) % 256;
        hist_q.push_front(y);
        if (hist_q.size() > 8) void'(hist_q.pop_back());
      end
    end
    bc = 0;
    dc = 0;
    dat = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_2);
      if (c == 0) begin
        mode = ~m;
        a_in = 2'($urandom);
        b_in = 2'($urandom);
        f_in = 3'($urandom);
      end
      if (retoggle && c == 4) start = 1'b0;
      if (retoggle && c == 5) start = 1'b1;
      if (busy) bc++;
      if (done) begin
        dc++;
        if (dat < 0) dat = c;
      end
    end
    check({tag, "_done_cnt"}, 32'(dc), 32'd1);
    check({tag, "_busy_cnt"}, 32'(bc), 32'(nops));
    check({tag, "_done_at"}, 32'(dat), 32'(nops));
    check({tag, "_result"}, 32'(result), 32'(exp_res));
    check({tag, "_checksum"}, 32'(checksum), 32'(exp_cks));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check_hist(tag);
    start = 1'b0;
  endtask

  initial begin
    int bc;
    int dc;
    repeat (3) @(negedge clk_2);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_checksum", 32'(checksum), 32'd0);
    check("rst_alu", 32'({alu_a, alu_b, alu_f}), 32'd0);
    check_hist("rst");
    reset = 1'b0;

    run_op(1'b0, 3, 1, 0, 1'b0, "single_and");
    check("single_and_res_const", 32'(result), 32'd1);

    run_op(1'b1, 0, 0, 2, 1'b0, "sweep_add");
    check("sweep_add_cks_const", 32'(checksum), 32'h18);
    hist_idx = 3'd0;
    #1;
    check("sweep_add_h0_const", 32'(hist_data), 32'd2);
    hist_idx = 3'd1;
    #1;
    check("sweep_add_h1_const", 32'(hist_data), 32'd1);

    run_op(1'b1, 0, 0, 0, 1'b0, "sweep_and");
    check("sweep_and_cks_const", 32'(checksum), 32'h0c);
    run_op(1'b1, 0, 0, 7, 1'b0, "sweep_slt");
    check("sweep_slt_cks_const", 32'(checksum), 32'h06);

    run_op(1'b0, 1, 2, 3, 1'b0, "undef");

    run_op(1'b1, 0, 0, 6, 1'b1, "retoggle");

    @(negedge clk_2);
    start = 1'b0;
    mode = 1'b1;
    f_in = 3'd2;
    @(negedge clk_2);
    start = 1'b1;
    bc = 0;
    for (int c = 0; c < 10 && bc < 5; c++) begin
      @(negedge clk_2);
      if (busy) bc++;
    end
    check("midrst_reached", 32'(bc), 32'd5);
    reset = 1'b1;
    start = 1'b0;
    hist_q.delete();
    exp_cks = 0;
    exp_res = '0;
    exp_err = 1'b0;
    @(negedge clk_2);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_checksum", 32'(checksum), 32'd0);
    check_hist("midrst");
    reset = 1'b0;
    dc = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_2);
      if (done || busy) dc++;
    end
    check("midrst_quiet", 32'(dc), 32'd0);

    for (int k = 0; k < 12; k++) begin
      run_op(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
             1'b0, $sformatf("rand%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ula_sweep_driver.md
Name: ula_sweep_driver

Overview:
- Initiator side of the 2-bit ULA operand/function interface.
- Registers and drives operands `a`, `b` and function `f` into the combinational ULA, then captures `y` one cycle later.
- Runs either one operation or a full 16-combination sweep for a chosen `f`.
- Keeps an 8-bit checksum and a circular history of results for the LED/LCD debug outputs in `top`.

Parameters:
- NBITS_OPERADORES, 2, operand width.
- NBITS_F, 3, function code width.
- NBITS_RESULTADO, 2, ULA result width.
- HIST_DEPTH, 8, history entries (power of two, ≥2).

Ports:
- clk_2  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  level from a switch; only its rising edge launches a run.
- mode  input  1  0 = single operation, 1 = sweep.
- a_in  input  NBITS_OPERADORES  operand a (single mode).
- b_in  input  NBITS_OPERADORES  operand b (single mode).
- f_in  input  NBITS_F  function code.
- alu_a  output  NBITS_OPERADORES  operand a to ULA.
- alu_b  output  NBITS_OPERADORES  operand b to ULA.
- alu_f  output  NBITS_F  function code to ULA.
- alu_y  input  NBITS_RESULTADO  ULA result.
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse at end of a run.
- err  output  1  last run used an undefined f.
- result  output  NBITS_RESULTADO  last captured y.
- checksum  output  8  mod-256 sum of y over the current/last run.
- hist_idx  input  $clog2(HIST_DEPTH)  history read index; 0 = most recent.
- hist_data  output  NBITS_RESULTADO  history entry; 0 if hist_idx ≥ count.

Behaviour:
- Reset (synchronous, active-high) sets state IDLE and clears all of:
  - outputs alu_a/alu_b/alu_f, busy, done, err, result, checksum;
  - start_q, history pointer and count.
- start_rise = start & ~start_q. start_q is registered every cycle.
- States and transitions:
  - IDLE:
    - On start_rise with f_in == 3'b011 (undefined): err←1, go to DONE, no capture.
    - On start_rise otherwise: latch f_in into alu_f, clear err and checksum, then:
      - single mode: alu_a←a_in, alu_b←b_in;
      - sweep mode: alu_a←0, alu_b←0.
      Then go to CAPTURE.
  - CAPTURE (busy=1), on each edge:
    - result←alu_y; checksum←checksum+alu_y (zero-extended, wraps mod 256);
    - push alu_y into history.
    - Single mode: go to DONE.
    - Sweep mode: b increments in the inner loop, a in the outer loop (b wraps 3→0 and increments a). After the capture of (a=3,b=3) go to DONE; otherwise stay in CAPTURE.
  - DONE: done=1 for exactly one cycle (combinational decode of state), busy=0, then IDLE.
- Latency:
  - Single mode: result is valid 2 edges after the start_rise edge; done is high in the following cycle.
  - Sweep mode: 16 capture edges, one operation per cycle.
- mode, a_in, b_in and f_in are sampled only at the start_rise edge; later changes are ignored.
- start_rise outside IDLE is dropped, not queued. Holding start high never relaunches a run.
- alu_a/alu_b/alu_f hold their last values in IDLE and DONE.
- History:
  - Write pointer wraps at HIST_DEPTH.
  - count saturates at HIST_DEPTH.
  - Read is combinational.
- Reset mid-run: IDLE on the next edge, no done pulse, history emptied.

Optional Feature:
- ULA_SELF_CHECK_EN defined:
  - An internal reference model computes the expected y from alu_a/alu_b/alu_f with semantics:
    - 000 and, 001 or, 010 add, 100 a&~b, 101 a|~b, 110 sub, 111 slt; all truncated to NBITS_RESULTADO.
  - Every CAPTURE compares alu_y with the expected value.
  - Extra output ports:
    - mismatch (1 bit): sticky until reset or the next start_rise.
    - mismatch_cnt (8 bits): saturating.
- Not defined: no model, no extra ports.

Decomposition:
- Package ula_pkg holds:
  - width parameters;
  - state enum {IDLE, CAPTURE, DONE};
  - f opcode localparams (F_AND, F_OR, F_ADD, F_ANDN, F_ORN, F_SUB, F_SLT, F_UNDEF=3'b011);
  - the reference function ula_ref used by SELF_CHECK.
- One sub-module, ula_hist_buf: circular buffer with push, pointer, saturating count and indexed read.

Test Plan:
- Single mode, f=000, a=3, b=1, start rises → alu_y=1 captured two edges later; result=1, checksum=0x01, done pulses once, err=0.
- Sweep, f=010 (add) → 16 busy cycles, checksum=0x18; hist_idx 0 → 2 (a=3,b=3), hist_idx 1 → 1.
- Sweep with f=000 → checksum=0x0C; sweep with f=111 → checksum=0x06. After either sweep, hist_idx 7 returns valid data (count saturated at 8).
- f=011, start rises → err=1, done pulses the next cycle, busy never asserts, result/checksum unchanged from the prior run.
- start held high across the run and re-toggled while busy → exactly one run and one done pulse.
- Reset asserted at sweep cycle 5 → next edge gives busy=0, checksum=0, hist_data=0 for all indices, no done pulse.
